counter_bank: RTL and testbench

Parametrised bank of N_CH independent up/down counters, all in the sys_clk domain. This is the next generation of the two-counter endpoint sample.
- Each channel has its own prescaler, auto-count enable, manual up/down pulses, and a selectable wrap or saturate mode.
- Each channel has a programmable compare value.
- Outputs feed WireOut endpoints (count values) and TriggerOut endpoints (event pulses). Control inputs come from WireIn and TriggerIn endpoints.

---
 rtl/counter_bank_pkg.sv | 17 +
 rtl/counter_bank_channel.sv | 101 ++++++++++
 rtl/counter_bank.sv | 47 ++++
 tb/tb_counter_bank.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Shared widths, delta range and helpers for the counter bank.
// The default widths match the endpoint integration.
package counter_bank_pkg;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_DIV_W = 24;

  // One cycle can move a count by at most -1 (down) or +2 (up plus auto tick).
  localparam int DELTA_MIN = -1;
  localparam int DELTA_MAX = 2;

  function automatic logic [31:0] cnt_max(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One channel: prescaler, up/down counter with wrap or saturate, level flags and event pulses.
// Arithmetic is done in CNT_W+2 signed bits so both overflow directions stay visible.
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ch_reset,
  input  logic             ch_auto,
  input  logic             ch_sat,
  input  logic             ch_up,
  input  logic             ch_down,
  input  logic [DIV_W-1:0] div_reload,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             eq_zero,
  output logic             eq_cmp,
  output logic             cmp_hit,
  output logic             limit_hit
);

  localparam logic [31:0]             MAX_32 = cnt_max(CNT_W);
  localparam logic signed [CNT_W+1:0] MAX_S  = $signed({2'b00, MAX_32[CNT_W-1:0]});

  logic [DIV_W-1:0]        div_cnt_p1;
  logic                    tick_p1;
  logic [CNT_W-1:0]        count_p1;
  logic                    eq_zero_p1;
  logic                    eq_cmp_p1;
  logic                    cmp_hit_p1;
  logic                    limit_hit_p1;

  logic signed [CNT_W+1:0] sum_p0;
  logic [CNT_W-1:0]        next_p0;
  logic                    over_p0;

  function automatic logic out_of_range(input logic signed [CNT_W+1:0] v);
    return v[CNT_W+1] || (v > MAX_S);
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+1:0] v);
    if (v[CNT_W+1])
      return '0;
    else if (v > MAX_S)
      return MAX_S[CNT_W-1:0];
    else
      return v[CNT_W-1:0];
  endfunction

  // Stage p0: combinational next count from current count and sampled controls.
  always_comb begin
    sum_p0 = $signed({2'b00, count_p1})
           + $signed({{(CNT_W+1){1'b0}}, ch_up})
           + $signed({{(CNT_W+1){1'b0}}, ch_auto & tick_p1})
           - $signed({{(CNT_W+1){1'b0}}, ch_down});
    over_p0 = out_of_range(sum_p0);
    next_p0 = ch_sat ? sat_cnt(sum_p0) : sum_p0[CNT_W-1:0];
  end

  // Stage p1: registered prescaler, count, flags and pulses.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      div_cnt_p1   <= '0;
      tick_p1      <= 1'b0;
      count_p1     <= '0;
      eq_zero_p1   <= 1'b0;
      eq_cmp_p1    <= 1'b0;
      cmp_hit_p1   <= 1'b0;
      limit_hit_p1 <= 1'b0;
    end else begin
      if (div_cnt_p1 == '0) begin
        div_cnt_p1 <= div_reload;
        tick_p1    <= 1'b1;
      end else begin
        div_cnt_p1 <= div_cnt_p1 - DIV_W'(1);
        tick_p1    <= 1'b0;
      end
      eq_zero_p1 <= (count_p1 == '0);
      eq_cmp_p1  <= (count_p1 == cmp_val);
      if (ch_reset) begin
        count_p1     <= '0;
        cmp_hit_p1   <= 1'b0;
        limit_hit_p1 <= 1'b0;
      end else begin
        count_p1     <= next_p0;
        cmp_hit_p1   <= (next_p0 == cmp_val) && (count_p1 != cmp_val);
        limit_hit_p1 <= over_p0;
      end
    end
  end

  assign count     = count_p1;
  assign eq_zero   = eq_zero_p1;
  assign eq_cmp    = eq_cmp_p1;
  assign cmp_hit   = cmp_hit_p1;
  assign limit_hit = limit_hit_p1;

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH independent up/down counters; slices the flattened endpoint buses per channel.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       ch_reset,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       ch_sat,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH*DIV_W-1:0] div_reload,
  input  logic [N_CH*CNT_W-1:0] cmp_val,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       eq_zero,
  output logic [N_CH-1:0]       eq_cmp,
  output logic [N_CH-1:0]       cmp_hit,
  output logic [N_CH-1:0]       limit_hit
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_channel #(
      .CNT_W (CNT_W),
      .DIV_W (DIV_W)
    ) u_ch (
      .sys_clk    (sys_clk),
      .reset      (reset),
      .ch_reset   (ch_reset[i]),
      .ch_auto    (ch_auto[i]),
      .ch_sat     (ch_sat[i]),
      .ch_up      (ch_up[i]),
      .ch_down    (ch_down[i]),
      .div_reload (div_reload[i*DIV_W +: DIV_W]),
      .cmp_val    (cmp_val[i*CNT_W +: CNT_W]),
      .count      (count[i*CNT_W +: CNT_W]),
      .eq_zero    (eq_zero[i]),
      .eq_cmp     (eq_cmp[i]),
      .cmp_hit    (cmp_hit[i]),
      .limit_hit  (limit_hit[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed scenarios plus randomized traffic
// checked against an integer reference model of the counter rules.
module tb_counter_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int DIV_W = 24;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic                  sys_clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       ch_reset, ch_auto, ch_sat, ch_up, ch_down;
  logic [N_CH*DIV_W-1:0] div_reload;
  logic [N_CH*CNT_W-1:0] cmp_val;
  logic [N_CH*CNT_W-1:0] count;
  logic [N_CH-1:0]       eq_zero, eq_cmp, cmp_hit, limit_hit;

  int checks   = 0;
  int failures = 0;

  int m_cnt [N_CH];
  int m_div [N_CH];
  bit m_tick[N_CH];
  bit m_eqz [N_CH];
  bit m_eqc [N_CH];
  bit m_hit [N_CH];
  bit m_lim [N_CH];

  always #5 sys_clk = ~sys_clk;

  counter_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .ch_reset   (ch_reset),
    .ch_auto    (ch_auto),
    .ch_sat     (ch_sat),
    .ch_up      (ch_up),
    .ch_down    (ch_down),
    .div_reload (div_reload),
    .cmp_val    (cmp_val),
    .count      (count),
    .eq_zero    (eq_zero),
    .eq_cmp     (eq_cmp),
    .cmp_hit    (cmp_hit),
    .limit_hit  (limit_hit)
  );

  // Reference model: plain integer arithmetic on the sampled inputs.
  function automatic void model_update();
    for (int ch = 0; ch < N_CH; ch++) begin
      if (reset) begin
        m_cnt[ch] = 0; m_div[ch] = 0; m_tick[ch] = 0;
        m_eqz[ch] = 0; m_eqc[ch] = 0; m_hit[ch] = 0; m_lim[ch] = 0;
      end else begin
        int old_c = m_cnt[ch];
        int cmpv  = int'(cmp_val[ch*CNT_W +: CNT_W]);
        int up_i  = ch_up[ch] ? 1 : 0;
        int dn_i  = ch_down[ch] ? 1 : 0;
        int au_i  = (ch_auto[ch] && m_tick[ch]) ? 1 : 0;
        int raw;
        int nxt;
        m_eqz[ch] = (old_c == 0);
        m_eqc[ch] = (old_c == cmpv);
        if (ch_reset[ch]) begin
          nxt = 0; m_hit[ch] = 0; m_lim[ch] = 0;
        end else begin
          raw = old_c + up_i + au_i - dn_i;
          m_lim[ch] = (raw < 0) || (raw > MAXV);
          if (ch_sat[ch]) nxt = (raw < 0) ? 0 : ((raw > MAXV) ? MAXV : raw);
          else            nxt = (raw + MAXV + 1) % (MAXV + 1);
          m_hit[ch] = (nxt == cmpv) && (old_c != cmpv);
        end
        m_cnt[ch] = nxt;
        m_tick[ch] = (m_div[ch] == 0);
        m_div[ch]  = m_tick[ch] ? int'(div_reload[ch*DIV_W +: DIV_W]) : m_div[ch] - 1;
      end
    end
  endfunction

  task automatic step();
    @(posedge sys_clk);
    model_update();
    #1;
  endtask

  task automatic load_count(input int ch, input int val);
    ch_reset[ch] = 1'b1;
    step();
    ch_reset[ch] = 1'b0;
    ch_up[ch] = 1'b1;
    for (int k = 0; k < val; k++) step();
    ch_up[ch] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    if (count !== '0) begin failures++; $display("FAIL reset_count got=%0h want=0", count); end
    checks++;
    if (eq_zero !== '0) begin failures++; $display("FAIL reset_eq_zero got=%0h want=0", eq_zero); end
    checks++;
    if (eq_cmp !== '0) begin failures++; $display("FAIL reset_eq_cmp got=%0h want=0", eq_cmp); end
    checks++;
    if (cmp_hit !== '0 || limit_hit !== '0) begin
      failures++; $display("FAIL reset_pulses got=%0h/%0h want=0/0", cmp_hit, limit_hit);
    end
    checks++;
    reset = 1'b0;
    step();
    if (eq_zero !== 4'hF) begin failures++; $display("FAIL post_reset_eq_zero got=%0h want=f", eq_zero); end
    checks++;
  endtask

  task automatic test_prescaler();
    reset = 1'b1;
    step();
    reset = 1'b0;
    div_reload[0 +: DIV_W] = 24'd3;
    ch_auto[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (count[7:0] !== 8'(m_cnt[0])) begin
        failures++; $display("FAIL presc_count cyc=%0d got=%0h want=%0h", k, count[7:0], m_cnt[0]);
      end
      checks++;
      if (eq_zero[0] !== m_eqz[0]) begin
        failures++; $display("FAIL presc_eq_zero cyc=%0d got=%0b want=%0b", k, eq_zero[0], m_eqz[0]);
      end
      checks++;
    end
    if (count[7:0] !== 8'd3) begin failures++; $display("FAIL presc_final got=%0h want=3", count[7:0]); end
    checks++;
    ch_auto[0] = 1'b0;
    div_reload[0 +: DIV_W] = '0;
  endtask

  task automatic test_wrap();
    ch_sat[0] = 1'b0;
    load_count(0, 'hFE);
    if (count[7:0] !== 8'hFE) begin failures++; $display("FAIL wrap_load got=%0h want=fe", count[7:0]); end
    checks++;
    ch_up[0] = 1'b1;
    step();
    if (count[7:0] !== 8'hFF || limit_hit[0] !== 1'b0) begin
      failures++; $display("FAIL wrap_ff got=%0h/%0b want=ff/0", count[7:0], limit_hit[0]);
    end
    checks++;
    step();
    if (count[7:0] !== 8'h00 || limit_hit[0] !== 1'b1) begin
      failures++; $display("FAIL wrap_00 got=%0h/%0b want=00/1", count[7:0], limit_hit[0]);
    end
    checks++;
    ch_up[0] = 1'b0;
    step();
    if (eq_zero[0] !== 1'b1 || limit_hit[0] !== 1'b0 || count[7:0] !== 8'h00) begin
      failures++; $display("FAIL wrap_after got=%0b/%0b/%0h want=1/0/00", eq_zero[0], limit_hit[0], count[7:0]);
    end
    checks++;
  endtask

  task automatic test_saturate();
    ch_sat[1] = 1'b1;
    load_count(1, 0);
    ch_down[1] = 1'b1;
    step();
    ch_down[1] = 1'b0;
    if (count[15:8] !== 8'h00 || limit_hit[1] !== 1'b1) begin
      failures++; $display("FAIL sat_low got=%0h/%0b want=00/1", count[15:8], limit_hit[1]);
    end
    checks++;
    step();
    if (limit_hit[1] !== 1'b0) begin failures++; $display("FAIL sat_low_hold got=%0b want=0", limit_hit[1]); end
    checks++;
    load_count(1, 255);
    if (count[15:8] !== 8'hFF) begin failures++; $display("FAIL sat_load got=%0h want=ff", count[15:8]); end
    checks++;
    ch_up[1] = 1'b1;
    ch_auto[1] = 1'b1;
    step();
    if (count[15:8] !== 8'hFF || limit_hit[1] !== 1'b1) begin
      failures++; $display("FAIL sat_high got=%0h/%0b want=ff/1", count[15:8], limit_hit[1]);
    end
    checks++;
    ch_up[1] = 1'b0;
    ch_auto[1] = 1'b0;
    step();
    if (count[15:8] !== 8'hFF || limit_hit[1] !== 1'b0) begin
      failures++; $display("FAIL sat_high_hold got=%0h/%0b want=ff/0", count[15:8], limit_hit[1]);
    end
    checks++;
  endtask

  task automatic test_up_down();
    ch_sat[2] = 1'b0;
    load_count(2, 'h10);
    ch_up[2] = 1'b1;
    ch_down[2] = 1'b1;
    step();
    if (count[23:16] !== 8'h10 || limit_hit[2] !== 1'b0 || cmp_hit[2] !== 1'b0) begin
      failures++; $display("FAIL updown_hold got=%0h/%0b/%0b want=10/0/0", count[23:16], limit_hit[2], cmp_hit[2]);
    end
    checks++;
    ch_down[2] = 1'b0;
    ch_auto[2] = 1'b1;
    step();
    if (count[23:16] !== 8'h12) begin failures++; $display("FAIL updown_plus2 got=%0h want=12", count[23:16]); end
    checks++;
    ch_up[2] = 1'b0;
    ch_auto[2] = 1'b0;
  endtask

  task automatic test_compare();
    ch_sat[3] = 1'b0;
    cmp_val[31:24] = 8'h05;
    load_count(3, 4);
    if (count[31:24] !== 8'h04) begin failures++; $display("FAIL cmp_load got=%0h want=04", count[31:24]); end
    checks++;
    ch_up[3] = 1'b1;
    step();
    ch_up[3] = 1'b0;
    if (count[31:24] !== 8'h05 || cmp_hit[3] !== 1'b1) begin
      failures++; $display("FAIL cmp_hit got=%0h/%0b want=05/1", count[31:24], cmp_hit[3]);
    end
    checks++;
    step();
    if (eq_cmp[3] !== 1'b1 || cmp_hit[3] !== 1'b0) begin
      failures++; $display("FAIL cmp_eq got=%0b/%0b want=1/0", eq_cmp[3], cmp_hit[3]);
    end
    checks++;
    cmp_val[31:24] = 8'h06;
    step();
    if (cmp_hit[3] !== 1'b0 || eq_cmp[3] !== 1'b0) begin
      failures++; $display("FAIL cmp_change got=%0b/%0b want=0/0", cmp_hit[3], eq_cmp[3]);
    end
    checks++;
    cmp_val[31:24] = 8'h05;
    step();
    if (cmp_hit[3] !== 1'b0 || eq_cmp[3] !== 1'b1) begin
      failures++; $display("FAIL cmp_back got=%0b/%0b want=0/1", cmp_hit[3], eq_cmp[3]);
    end
    checks++;
  endtask

  task automatic test_ch_reset();
    ch_auto = '1;
    ch_sat = '0;
    div_reload = '0;
    cmp_val[23:16] = 8'h00;
    for (int k = 0; k < 5; k++) step();
    ch_reset[2] = 1'b1;
    ch_up[2] = 1'b1;
    step();
    ch_reset[2] = 1'b0;
    ch_up[2] = 1'b0;
    if (count[23:16] !== 8'h00 || cmp_hit[2] !== 1'b0 || limit_hit[2] !== 1'b0) begin
      failures++; $display("FAIL chrst_clear got=%0h/%0b/%0b want=00/0/0", count[23:16], cmp_hit[2], limit_hit[2]);
    end
    checks++;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (ch != 2) begin
        if (count[ch*CNT_W +: CNT_W] !== 8'(m_cnt[ch])) begin
          failures++; $display("FAIL chrst_other ch=%0d got=%0h want=%0h", ch, count[ch*CNT_W +: CNT_W], m_cnt[ch]);
        end
        checks++;
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    ch_auto = '0;
    if (count !== '0 || eq_zero !== '0 || eq_cmp !== '0 || cmp_hit !== '0 || limit_hit !== '0) begin
      failures++; $display("FAIL global_reset got=%0h %0h %0h %0h %0h want=0", count, eq_zero, eq_cmp, cmp_hit, limit_hit);
    end
    checks++;
  endtask

  task automatic test_random();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        ch_reset[ch] = ($urandom_range(0, 24) == 0);
        ch_auto[ch]  = $urandom_range(0, 1);
        ch_up[ch]    = ($urandom_range(0, 2) == 0);
        ch_down[ch]  = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) ch_sat[ch] = $urandom_range(0, 1);
        if ($urandom_range(0, 15) == 0) div_reload[ch*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0)
          cmp_val[ch*CNT_W +: CNT_W] = $urandom_range(0, 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(251, 255));
      end
      step();
      for (int ch = 0; ch < N_CH; ch++) begin
        if (count[ch*CNT_W +: CNT_W] !== 8'(m_cnt[ch])) begin
          failures++; $display("FAIL rnd_count cyc=%0d ch=%0d got=%0h want=%0h", cyc, ch, count[ch*CNT_W +: CNT_W], m_cnt[ch]);
        end
        checks++;
        if (eq_zero[ch] !== m_eqz[ch] || eq_cmp[ch] !== m_eqc[ch]) begin
          failures++; $display("FAIL rnd_flags cyc=%0d ch=%0d got=%0b%0b want=%0b%0b", cyc, ch, eq_zero[ch], eq_cmp[ch], m_eqz[ch], m_eqc[ch]);
        end
        checks++;
        if (cmp_hit[ch] !== m_hit[ch]) begin
          failures++; $display("FAIL rnd_cmp_hit cyc=%0d ch=%0d got=%0b want=%0b", cyc, ch, cmp_hit[ch], m_hit[ch]);
        end
        checks++;
        if (limit_hit[ch] !== m_lim[ch]) begin
          failures++; $display("FAIL rnd_limit_hit cyc=%0d ch=%0d got=%0b want=%0b", cyc, ch, limit_hit[ch], m_lim[ch]);
        end
        checks++;
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    ch_reset   = '0;
    ch_auto    = '0;
    ch_sat     = '0;
    ch_up      = '0;
    ch_down    = '0;
    div_reload = '0;
    cmp_val    = {N_CH{8'hAA}};
    test_reset();
    test_prescaler();
    test_wrap();
    test_saturate();
    test_up_down();
    test_compare();
    test_ch_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
